z80_cb_ind_hl_seq: RTL and testbench

- Machine-cycle sequencer for CB-prefixed instructions with an (HL) operand: BIT b,(HL), RES b,(HL), SET b,(HL) and the eight rotate/shift ops on (HL).
- Drives the core's bus machine cycles (M1 fetch of the CB prefix, M1 fetch of the opcode, memory read at HL, optional memory write-back at HL).
- Computes the result byte and the new F, and reports IP and F to the register file on completion.
- Sits between the main decoder, which hands it an instruction start, and the bus cycle unit.

---
 rtl/z80_cb_ind_hl_seq_if.sv | 43 ++++
 rtl/z80_cb_ind_hl_seq.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_z80_cb_ind_hl_seq.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/z80_cb_ind_hl_seq_if.sv
// Bus and handshake bundle between the CB (HL) sequencer, the main decoder,
// the register file and the bus cycle unit.
`ifndef Z80_CB_CYCLE_DEFS
`define Z80_CB_CYCLE_DEFS
`define CYCLE_NONE     3'd0
`define CYCLE_M1       3'd1
`define CYCLE_RDWR_MEM 3'd2
`endif

interface z80_cb_ind_hl_seq_if;
   logic        start;
   logic [15:0] ip_in;
   logic [15:0] hl_in;
   logic [7:0]  f_in;
   logic [7:0]  bus_rdata;
   logic        wait_n;
   logic [2:0]  mcycle_type;
   logic [15:0] bus_addr;
   logic        bus_rd;
   logic        bus_wr;
   logic [7:0]  bus_wdata;
   logic        busy;
   logic        done;
   logic [15:0] ip_out;
   logic [7:0]  f_out;
   logic        f_we;
   logic        illegal;
   logic        timeout;

   // Sequencer side
   modport master (
      input  start, ip_in, hl_in, f_in, bus_rdata, wait_n,
      output mcycle_type, bus_addr, bus_rd, bus_wr, bus_wdata,
             busy, done, ip_out, f_out, f_we, illegal, timeout
   );

   // Decoder / bus unit / register file side
   modport slave (
      output start, ip_in, hl_in, f_in, bus_rdata, wait_n,
      input  mcycle_type, bus_addr, bus_rd, bus_wr, bus_wdata,
             busy, done, ip_out, f_out, f_we, illegal, timeout
   );
endinterface

// File: rtl/z80_cb_ind_hl_seq.sv
// Machine-cycle sequencer for CB-prefixed (HL) instructions: BIT/RES/SET and
// the eight rotate/shift ops. Runs prefix fetch, opcode fetch, memory read at
// HL and an optional write-back, then reports IP and F. All outputs are
// registered; they are computed from the next state and next T-state.
module z80_cb_ind_hl_seq #(
   parameter int TW_MAX = 15
) (
   input logic                 clk,
   input logic                 reset_n,
   z80_cb_ind_hl_seq_if.master cb
);

   localparam int TWW = $clog2(TW_MAX + 2);
   localparam logic [TWW-1:0] TW_LIM = TWW'(TW_MAX);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_FETCH_CB = 3'd1,
      S_FETCH_OP = 3'd2,
      S_MEM_RD   = 3'd3,
      S_MEM_WR   = 3'd4,
      S_FINISH   = 3'd5
   } state_t;

   // Z80 P/V parity flag: set when the byte has an even number of ones.
   function automatic logic even_parity(input logic [7:0] v);
      return ~(^v);
   endfunction

   // Result byte and flags for one CB op; returns {f_we, f, result}.
   function automatic logic [16:0] cb_alu(input logic [7:0] op,
                                          input logic [7:0] d,
                                          input logic [7:0] f);
      logic [7:0] r;
      logic [7:0] fo;
      logic       c;
      logic       we;
      logic [2:0] b;
      b  = op[5:3];
      r  = d;
      fo = f;
      c  = f[0];
      we = 1'b0;
      case (op[7:6])
         2'b00: begin
            case (b)
               3'd0:    begin r = {d[6:0], d[7]};   c = d[7]; end // RLC
               3'd1:    begin r = {d[0], d[7:1]};   c = d[0]; end // RRC
               3'd2:    begin r = {d[6:0], f[0]};   c = d[7]; end // RL
               3'd3:    begin r = {f[0], d[7:1]};   c = d[0]; end // RR
               3'd4:    begin r = {d[6:0], 1'b0};   c = d[7]; end // SLA
               3'd5:    begin r = {d[7], d[7:1]};   c = d[0]; end // SRA
               3'd6:    begin r = {d[6:0], 1'b1};   c = d[7]; end // SLL
               3'd7:    begin r = {1'b0, d[7:1]};   c = d[0]; end // SRL
               default: begin r = d;                c = f[0]; end
            endcase
            fo = {r[7], (r == 8'h00), r[5], 1'b0, r[3], even_parity(r), 1'b0, c};
            we = 1'b1;
         end
         2'b01: begin
            fo = {((b == 3'd7) && d[7]), ~d[b], f[5], 1'b1, f[3], ~d[b], 1'b0, f[0]};
            we = 1'b1;
         end
         2'b10: begin
            r = d & ~(8'h01 << b);
         end
         2'b11: begin
            r = d | (8'h01 << b);
         end
         default: begin
            r = d;
         end
      endcase
      return {we, fo, r};
   endfunction

   state_t         state_q, state_d;
   logic [2:0]     t_q, t_d;
   logic [TWW-1:0] tw_q, tw_d;
   logic [15:0]    ip_q, ip_d;
   logic [7:0]     op_q, op_d;
   logic [7:0]     byte_q, byte_d;
   logic [7:0]     result_q, result_d;
   logic [7:0]     fhold_q, fhold_d;
   logic           fwe_hold_q, fwe_hold_d;
   logic           illegal_q, illegal_d;
   logic           timeout_q, timeout_d;

   logic [2:0]     mtype_q, mtype_d;
   logic [15:0]    addr_q, addr_d;
   logic           rd_q, rd_d;
   logic           wr_q, wr_d;
   logic [7:0]     wdata_q, wdata_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic [15:0]    ip_out_q, ip_out_d;
   logic [7:0]     f_out_q, f_out_d;
   logic           f_we_q, f_we_d;

   logic [2:0]     last_t_s;
   logic [16:0]    alu_s;

   assign last_t_s = ((state_q == S_FETCH_CB) || (state_q == S_FETCH_OP)) ? 3'd4 : 3'd3;
   assign alu_s    = cb_alu(op_q, cb.bus_rdata, cb.f_in);

   // Next state, T-state/wait counters and operand latching.
   always_comb begin
      state_d    = state_q;
      t_d        = t_q;
      tw_d       = tw_q;
      ip_d       = ip_q;
      op_d       = op_q;
      byte_d     = byte_q;
      result_d   = result_q;
      fhold_d    = fhold_q;
      fwe_hold_d = fwe_hold_q;
      illegal_d  = 1'b0;
      timeout_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cb.start) begin
               state_d = S_FETCH_CB;
               t_d     = 3'd1;
               tw_d    = '0;
               ip_d    = cb.ip_in;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FETCH_CB, S_FETCH_OP, S_MEM_RD, S_MEM_WR: begin
            if ((t_q == 3'd2) && !cb.wait_n) begin
               // Wait state: T-counter parks at T2
               if (tw_q == TW_LIM) begin
                  timeout_d = 1'b1;
                  state_d   = S_IDLE;
                  t_d       = 3'd0;
                  tw_d      = '0;
               end else begin
                  tw_d = tw_q + TWW'(1);
               end
            end else if (t_q != last_t_s) begin
               t_d = t_q + 3'd1;
               if (t_q == 3'd3) begin
                  byte_d = cb.bus_rdata;   // M1 data captured at end of T3
               end else begin
                  byte_d = byte_q;
               end
            end else begin
               // Last T-state of this M-cycle
               tw_d = '0;
               case (state_q)
                  S_FETCH_CB: begin
                     if (byte_q != 8'hCB) begin
                        illegal_d = 1'b1;
                        state_d   = S_IDLE;
                     end else begin
                        state_d = S_FETCH_OP;
                     end
                  end
                  S_FETCH_OP: begin
                     if (byte_q[2:0] != 3'b110) begin
                        illegal_d = 1'b1;
                        state_d   = S_IDLE;
                     end else begin
                        op_d    = byte_q;
                        state_d = S_MEM_RD;
                     end
                  end
                  S_MEM_RD: begin
                     result_d   = alu_s[7:0];
                     fhold_d    = alu_s[15:8];
                     fwe_hold_d = alu_s[16];
                     if (op_q[7:6] == 2'b01) begin
                        state_d = S_FINISH;
                     end else begin
                        state_d = S_MEM_WR;
                     end
                  end
                  S_MEM_WR: begin
                     state_d = S_FINISH;
                  end
                  default: begin
                     state_d = S_IDLE;
                  end
               endcase
               if ((state_d == S_FINISH) || (state_d == S_IDLE)) begin
                  t_d = 3'd0;
               end else begin
                  t_d = 3'd1;
               end
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
            t_d     = 3'd0;
         end
         default: begin
            state_d = S_IDLE;
            t_d     = 3'd0;
            tw_d    = '0;
         end
      endcase
   end

   // Bus and completion outputs for the upcoming clock, from next state.
   always_comb begin
      mtype_d  = `CYCLE_NONE;
      addr_d   = 16'h0000;
      rd_d     = 1'b0;
      wr_d     = 1'b0;
      wdata_d  = 8'h00;
      busy_d   = (state_d != S_IDLE);
      done_d   = 1'b0;
      ip_out_d = 16'h0000;
      f_out_d  = 8'h00;
      f_we_d   = 1'b0;
      case (state_d)
         S_FETCH_CB: begin
            mtype_d = `CYCLE_M1;
            addr_d  = ip_d;
            rd_d    = (t_d == 3'd1) || (t_d == 3'd2);
         end
         S_FETCH_OP: begin
            mtype_d = `CYCLE_M1;
            addr_d  = ip_d + 16'd1;
            rd_d    = (t_d == 3'd1) || (t_d == 3'd2);
         end
         S_MEM_RD: begin
            mtype_d = `CYCLE_RDWR_MEM;
            addr_d  = cb.hl_in;
            rd_d    = 1'b1;
         end
         S_MEM_WR: begin
            mtype_d = `CYCLE_RDWR_MEM;
            addr_d  = cb.hl_in;
            wr_d    = (t_d != 3'd1);
            wdata_d = result_d;
         end
         S_FINISH: begin
            done_d   = 1'b1;
            ip_out_d = ip_d + 16'd2;
            f_out_d  = fhold_d;
            f_we_d   = fwe_hold_d;
         end
         default: begin
            mtype_d = `CYCLE_NONE;
            addr_d  = 16'h0000;
         end
      endcase
   end

   // State, datapath and registered outputs; async reset aborts everything.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         t_q        <= 3'd0;
         tw_q       <= '0;
         ip_q       <= 16'h0000;
         op_q       <= 8'h00;
         byte_q     <= 8'h00;
         result_q   <= 8'h00;
         fhold_q    <= 8'h00;
         fwe_hold_q <= 1'b0;
         illegal_q  <= 1'b0;
         timeout_q  <= 1'b0;
         mtype_q    <= `CYCLE_NONE;
         addr_q     <= 16'h0000;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         wdata_q    <= 8'h00;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ip_out_q   <= 16'h0000;
         f_out_q    <= 8'h00;
         f_we_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         t_q        <= t_d;
         tw_q       <= tw_d;
         ip_q       <= ip_d;
         op_q       <= op_d;
         byte_q     <= byte_d;
         result_q   <= result_d;
         fhold_q    <= fhold_d;
         fwe_hold_q <= fwe_hold_d;
         illegal_q  <= illegal_d;
         timeout_q  <= timeout_d;
         mtype_q    <= mtype_d;
         addr_q     <= addr_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         wdata_q    <= wdata_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ip_out_q   <= ip_out_d;
         f_out_q    <= f_out_d;
         f_we_q     <= f_we_d;
      end
   end

   assign cb.mcycle_type = mtype_q;
   assign cb.bus_addr    = addr_q;
   assign cb.bus_rd      = rd_q;
   assign cb.bus_wr      = wr_q;
   assign cb.bus_wdata   = wdata_q;
   assign cb.busy        = busy_q;
   assign cb.done        = done_q;
   assign cb.ip_out      = ip_out_q;
   assign cb.f_out       = f_out_q;
   assign cb.f_we        = f_we_q;
   assign cb.illegal     = illegal_q;
   assign cb.timeout     = timeout_q;

endmodule

// File: tb/tb_z80_cb_ind_hl_seq.sv
// Self-checking bench for z80_cb_ind_hl_seq: a byte-array memory answers the
// bus, and expected results come from an arithmetic model of the CB ops.
`ifndef Z80_CB_CYCLE_DEFS
`define Z80_CB_CYCLE_DEFS
`define CYCLE_NONE     3'd0
`define CYCLE_M1       3'd1
`define CYCLE_RDWR_MEM 3'd2
`endif

module tb_z80_cb_ind_hl_seq;
   logic clk = 1'b0;
   logic reset_n;
   z80_cb_ind_hl_seq_if ifc();

   z80_cb_ind_hl_seq #(.TW_MAX(15)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .cb      (ifc)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [0:65535];
   assign ifc.bus_rdata = mem[ifc.bus_addr];

   int checks   = 0;
   int failures = 0;

   // observations from one run
   int          done_cyc, done_cyc2, done_cnt, ill_cyc, ill_cnt, to_cyc, to_cnt;
   int          wr_cnt, wr_after_rst, mem_cyc;
   logic        busy_c1, busy_end, got_fwe, rst_seen;
   logic [7:0]  got_f, got_wdata;
   logic [15:0] got_ip, got_waddr, fo_addr;
   logic [2:0]  fo_type;
   logic [57:0] rst_snap;

   // Expected result byte, F and F write enable from the instruction rules.
   function automatic void ref_cb(input logic [7:0] op, input logic [7:0] d,
                                  input logic [7:0] fin, output logic [7:0] r,
                                  output logic [7:0] f, output logic fwe);
      int b, x, res, cy, cin;
      b = int'(op[5:3]); x = int'(d); cin = int'(fin[0]);
      res = x; cy = 0; f = fin; fwe = 1'b0;
      if (op[7:6] == 2'b01) begin
         f = (fin & 8'h29) | 8'h10;
         if (((x >> b) & 1) == 0) f = f | 8'h44;
         if (b == 7 && x >= 128) f = f | 8'h80;
         fwe = 1'b1;
      end else if (op[7:6] == 2'b10) begin
         res = x & ~(1 << b);
      end else if (op[7:6] == 2'b11) begin
         res = x | (1 << b);
      end else begin
         case (b)
            0: begin res = x * 2 + x / 128;         cy = x / 128; end
            1: begin res = x / 2 + (x % 2) * 128;   cy = x % 2;   end
            2: begin res = x * 2 + cin;             cy = x / 128; end
            3: begin res = x / 2 + cin * 128;       cy = x % 2;   end
            4: begin res = x * 2;                   cy = x / 128; end
            5: begin res = x / 2 + (x / 128) * 128; cy = x % 2;   end
            6: begin res = x * 2 + 1;               cy = x / 128; end
            default: begin res = x / 2;             cy = x % 2;   end
         endcase
         res = res % 256;
         f = 8'(res & 8'hA8) | ((res == 0) ? 8'h40 : 8'h00)
           | (($countones(res) % 2 == 0) ? 8'h04 : 8'h00) | 8'(cy);
         fwe = 1'b1;
      end
      r = 8'(res);
   endfunction

   // Load memory, issue start, then watch 60 clocks; cycle 1 follows acceptance.
   task automatic run(input logic [15:0] ip, input logic [15:0] hl, input logic [7:0] fin,
                      input logic [7:0] pre, input logic [7:0] op, input logic [7:0] d,
                      input int ws, input int wl, input int hold, input int rst_cyc);
      logic [15:0] ip1;
      ip1 = ip + 16'd1;
      mem[ip] = pre; mem[ip1] = op; mem[hl] = d;
      done_cyc = 0; done_cyc2 = 0; done_cnt = 0; ill_cyc = 0; ill_cnt = 0;
      to_cyc = 0; to_cnt = 0; wr_cnt = 0; wr_after_rst = 0; mem_cyc = 0;
      busy_c1 = 1'b0; rst_seen = 1'b0; got_f = 8'h00; got_fwe = 1'b0; got_ip = 16'h0;
      got_wdata = 8'h00; got_waddr = 16'h0; fo_addr = 16'h0; fo_type = 3'd0; rst_snap = '1;
      @(negedge clk);
      ifc.ip_in = ip; ifc.hl_in = hl; ifc.f_in = fin; ifc.start = 1'b1; ifc.wait_n = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (c == rst_cyc + 1) reset_n = 1'b1;
         if (ifc.done) begin
            done_cnt++;
            if (done_cnt == 1) begin
               done_cyc = c; got_f = ifc.f_out; got_fwe = ifc.f_we; got_ip = ifc.ip_out;
            end else begin
               done_cyc2 = c;
            end
         end
         if (ifc.illegal) begin ill_cnt++; ill_cyc = c; end
         if (ifc.timeout) begin to_cnt++; to_cyc = c; end
         if (ifc.bus_wr) begin
            wr_cnt++; got_waddr = ifc.bus_addr; got_wdata = ifc.bus_wdata;
            if (rst_seen) wr_after_rst++;
         end
         if (ifc.mcycle_type == `CYCLE_RDWR_MEM) mem_cyc++;
         if (c == 1) busy_c1 = ifc.busy;
         if (c == 5) begin fo_addr = ifc.bus_addr; fo_type = ifc.mcycle_type; end
         if (c >= hold) ifc.start = 1'b0;
         ifc.wait_n = !(c >= ws && c < ws + wl);
         if (c == rst_cyc) begin
            #2 reset_n = 1'b0;
            #1 rst_snap = {ifc.mcycle_type, ifc.bus_addr, ifc.bus_rd, ifc.bus_wr, ifc.bus_wdata,
                           ifc.busy, ifc.done, ifc.ip_out, ifc.f_out, ifc.f_we, ifc.illegal, ifc.timeout};
            rst_seen = 1'b1;
         end
      end
      busy_end = ifc.busy;
      ifc.start = 1'b0; ifc.wait_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b1;
      #3 reset_n = 1'b0;
      #1;
      checks++;
      if ({ifc.mcycle_type, ifc.bus_addr, ifc.bus_rd, ifc.bus_wr, ifc.bus_wdata, ifc.busy, ifc.done,
           ifc.ip_out, ifc.f_out, ifc.f_we, ifc.illegal, ifc.timeout} !== 58'd0) begin
         failures++; $display("FAIL reset_outputs: got nonzero outputs, required all zero");
      end
      repeat (3) @(negedge clk);
      checks++;
      if (ifc.busy !== 1'b0 || ifc.mcycle_type !== `CYCLE_NONE) begin
         failures++; $display("FAIL reset_hold: busy=%b mtype=%0d required 0/0", ifc.busy, ifc.mcycle_type);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_bit7();
      run(16'h1000, 16'h2000, 8'h01, 8'hCB, 8'h7E, 8'h80, 0, 0, 1, 0);
      checks++; if (done_cyc !== 12) begin failures++; $display("FAIL bit7_done_cycle: got %0d required 12", done_cyc); end
      checks++; if (got_f !== 8'h91) begin failures++; $display("FAIL bit7_f_out: got %h required 91", got_f); end
      checks++; if (got_fwe !== 1'b1) begin failures++; $display("FAIL bit7_f_we: got %b required 1", got_fwe); end
      checks++; if (got_ip !== 16'h1002) begin failures++; $display("FAIL bit7_ip_out: got %h required 1002", got_ip); end
      checks++; if (wr_cnt !== 0) begin failures++; $display("FAIL bit7_no_write: got %0d write clocks required 0", wr_cnt); end
      checks++; if (mem_cyc !== 3) begin failures++; $display("FAIL bit7_mem_clocks: got %0d required 3", mem_cyc); end
      checks++; if (busy_c1 !== 1'b1 || busy_end !== 1'b0) begin
         failures++; $display("FAIL bit7_busy: got first=%b end=%b required 1/0", busy_c1, busy_end); end
      checks++; if (done_cnt !== 1) begin failures++; $display("FAIL bit7_done_pulse: got %0d required 1", done_cnt); end
   endtask

   task automatic test_set0();
      run(16'h1000, 16'h2000, 8'h5A, 8'hCB, 8'hC6, 8'h00, 0, 0, 1, 0);
      checks++; if (done_cyc !== 15) begin failures++; $display("FAIL set0_done_cycle: got %0d required 15", done_cyc); end
      checks++; if (wr_cnt !== 2 || got_waddr !== 16'h2000 || got_wdata !== 8'h01) begin
         failures++; $display("FAIL set0_write: got n=%0d addr=%h data=%h required 2/2000/01", wr_cnt, got_waddr, got_wdata); end
      checks++; if (got_fwe !== 1'b0 || got_f !== 8'h5A) begin
         failures++; $display("FAIL set0_flags: got we=%b f=%h required 0/5a", got_fwe, got_f); end
   endtask

   task automatic test_rotates();
      run(16'h1000, 16'h2000, 8'h00, 8'hCB, 8'h06, 8'h81, 0, 0, 1, 0);
      checks++; if (got_wdata !== 8'h03 || got_f !== 8'h05 || done_cyc !== 15) begin
         failures++; $display("FAIL rlc: got data=%h f=%h cyc=%0d required 03/05/15", got_wdata, got_f, done_cyc); end
      run(16'h1000, 16'h2000, 8'h01, 8'hCB, 8'h16, 8'h00, 0, 0, 1, 0);
      checks++; if (got_wdata !== 8'h01 || got_f !== 8'h00 || got_fwe !== 1'b1) begin
         failures++; $display("FAIL rl: got data=%h f=%h we=%b required 01/00/1", got_wdata, got_f, got_fwe); end
   endtask

   task automatic test_wait();
      run(16'h3000, 16'h4000, 8'hFF, 8'hCB, 8'h46, 8'h01, 10, 2, 1, 0);
      checks++; if (done_cyc !== 14 || got_f !== 8'h39) begin
         failures++; $display("FAIL wait2_bit0: got cyc=%0d f=%h required 14/39", done_cyc, got_f); end
      run(16'h3000, 16'h4000, 8'hFF, 8'hCB, 8'h46, 8'hFE, 10, 15, 1, 0);
      checks++; if (done_cyc !== 27 || to_cnt !== 0 || got_f !== 8'h7D) begin
         failures++; $display("FAIL wait15_max: got cyc=%0d to=%0d f=%h required 27/0/7d", done_cyc, to_cnt, got_f); end
      run(16'h3000, 16'h4000, 8'hFF, 8'hCB, 8'h46, 8'h01, 10, 16, 1, 0);
      checks++; if (to_cnt !== 1 || to_cyc !== 26 || done_cnt !== 0 || busy_end !== 1'b0) begin
         failures++; $display("FAIL wait16_timeout: got to=%0d at %0d done=%0d required 1 at 26, 0 done", to_cnt, to_cyc, done_cnt); end
   endtask

   task automatic test_illegal();
      run(16'h1000, 16'h2000, 8'h00, 8'hCB, 8'h47, 8'h55, 0, 0, 1, 0);
      checks++; if (ill_cnt !== 1 || ill_cyc !== 9 || mem_cyc !== 0 || done_cnt !== 0) begin
         failures++; $display("FAIL illegal_op: got n=%0d cyc=%0d mem=%0d done=%0d required 1/9/0/0", ill_cnt, ill_cyc, mem_cyc, done_cnt); end
      run(16'h1000, 16'h2000, 8'h00, 8'hED, 8'h46, 8'h55, 0, 0, 1, 0);
      checks++; if (ill_cnt !== 1 || ill_cyc !== 5 || fo_type !== `CYCLE_NONE || done_cnt !== 0) begin
         failures++; $display("FAIL illegal_prefix: got n=%0d cyc=%0d mtype=%0d required 1/5/0", ill_cnt, ill_cyc, fo_type); end
   endtask

   task automatic test_ip_wrap();
      run(16'hFFFF, 16'h2000, 8'h00, 8'hCB, 8'h86, 8'hFF, 0, 0, 1, 0);
      checks++; if (fo_addr !== 16'h0000 || fo_type !== `CYCLE_M1) begin
         failures++; $display("FAIL wrap_fetch_addr: got %h type %0d required 0000/1", fo_addr, fo_type); end
      checks++; if (got_ip !== 16'h0001 || got_wdata !== 8'hFE) begin
         failures++; $display("FAIL wrap_ip_out: got ip=%h data=%h required 0001/fe", got_ip, got_wdata); end
   endtask

   task automatic test_reset_mid();
      run(16'h1000, 16'h2000, 8'h00, 8'hCB, 8'hDE, 8'h00, 0, 0, 1, 13);
      checks++; if (rst_snap !== 58'd0) begin failures++; $display("FAIL midreset_outputs: got %h required 0", rst_snap); end
      checks++; if (wr_cnt !== 1 || wr_after_rst !== 0 || done_cnt !== 0 || busy_end !== 1'b0) begin
         failures++; $display("FAIL midreset_abort: got wr=%0d post=%0d done=%0d required 1/0/0", wr_cnt, wr_after_rst, done_cnt); end
   endtask

   task automatic test_back_to_back();
      run(16'h1000, 16'h2000, 8'h00, 8'hCB, 8'h4E, 8'h02, 0, 0, 13, 0);
      checks++; if (done_cnt !== 1 || done_cyc !== 12) begin
         failures++; $display("FAIL start_ignored_busy: got n=%0d cyc=%0d required 1/12", done_cnt, done_cyc); end
      run(16'h1000, 16'h2000, 8'h00, 8'hCB, 8'h4E, 8'h02, 0, 0, 14, 0);
      checks++; if (done_cnt !== 2 || done_cyc2 !== 25) begin
         failures++; $display("FAIL back_to_back: got n=%0d second=%0d required 2/25", done_cnt, done_cyc2); end
   endtask

   task automatic test_random();
      logic [7:0]  op, d, fin, er, ef;
      logic [15:0] ip, hl;
      logic        efwe;
      int          ws, wl, base;
      for (int i = 0; i < 24; i++) begin
         op  = {2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'b110};
         d   = 8'($urandom_range(0, 255));
         fin = 8'($urandom_range(0, 255));
         ip  = 16'($urandom_range(0, 32'h7FF0));
         hl  = 16'(32'h8000 + $urandom_range(0, 32'h7FFF));
         wl  = $urandom_range(0, 4);
         case ($urandom_range(0, 2))
            0:       ws = 2;
            1:       ws = 6;
            default: ws = 10;
         endcase
         ref_cb(op, d, fin, er, ef, efwe);
         base = (op[7:6] == 2'b01) ? 12 : 15;
         run(ip, hl, fin, 8'hCB, op, d, ws, wl, 1, 0);
         checks++; if (done_cyc !== base + wl || done_cnt !== 1) begin
            failures++; $display("FAIL rand_timing op=%h: got cyc=%0d n=%0d required %0d/1", op, done_cyc, done_cnt, base + wl); end
         checks++; if (got_f !== ef || got_fwe !== efwe) begin
            failures++; $display("FAIL rand_flags op=%h d=%h f=%h: got %h/%b required %h/%b", op, d, fin, got_f, got_fwe, ef, efwe); end
         checks++; if (got_ip !== ip + 16'd2) begin
            failures++; $display("FAIL rand_ip op=%h: got %h required %h", op, got_ip, ip + 16'd2); end
         checks++; if (wr_cnt !== ((op[7:6] == 2'b01) ? 0 : 2)) begin
            failures++; $display("FAIL rand_wr_count op=%h: got %0d", op, wr_cnt); end
         if (op[7:6] != 2'b01) begin
            checks++; if (got_wdata !== er || got_waddr !== hl) begin
               failures++; $display("FAIL rand_wdata op=%h d=%h: got %h@%h required %h@%h", op, d, got_wdata, got_waddr, er, hl); end
         end
      end
   endtask

   initial begin
      ifc.start = 1'b0; ifc.ip_in = 16'h0; ifc.hl_in = 16'h0; ifc.f_in = 8'h0; ifc.wait_n = 1'b1;
      test_reset();
      test_bit7();
      test_set0();
      test_rotates();
      test_wait();
      test_illegal();
      test_ip_wrap();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
